fir_mac_pipe: RTL and testbench
===============================

# fir_mac_pipe

Pipelined, parameterised multiply-accumulate engine for the FIR datapath. It accepts one coefficient/sample pair per cycle over a valid/ready stream and accumulates taps into a wide guarded accumulator. On the tap flagged last it emits one rounded, saturated output word with tap count and saturation status, then starts the next frame automatically. Widths, output scaling and rounding mode are configurable; it sits between the tap sequencer (upstream) and the output sample FIFO (downstream).

## Interface
- DATA_W, 16: signed sample width (default Q1.15)
- COEF_W, 16: signed coefficient width (default Q1.15)
- ACC_W, 40: accumulator width; must be >= DATA_W+COEF_W+guard bits
- OUT_W, 16: signed output width
- SHIFT, 21: right shift from product fraction bits to output fraction bits (default Q2.30 -> Q7.9); must be 1..ACC_W-OUT_W
- CNT_W, 8: tap counter width

- clk  in  1  clock, all state on rising edge
- rstn  in  1  asynchronous active-low reset
- clr  in  1  synchronous flush: drops frame and pipeline, clears sat_sticky
- round_mode  in  2  0 truncate (floor), 1 round-half-up, 2 convergent (half-to-even), 3 same as 1; sampled at the last-tap accumulate edge
- in_valid  in  1  tap pair valid
- in_ready  out  1  engine can accept a tap
- in_a  in  DATA_W  signed sample
- in_b  in  COEF_W  signed coefficient
- in_last  in  1  final tap of frame
- out_valid  out  1  result held in output register
- out_ready  in  1  downstream accepts result
- out_y  out  OUT_W  rounded, saturated result
- out_sat  out  1  this result was clipped
- out_taps  out  CNT_W  taps accumulated in this frame (wraps mod 2^CNT_W)
- sat_sticky  out  1  OR of out_sat since reset/clr

## Operation
- Advance condition adv = !out_valid || out_ready; in_ready = adv && !clr.
- Stage 1 (on accept, in_valid && in_ready): p <= in_a*in_b (signed, DATA_W+COEF_W bits), p_valid <= 1, p_last <= in_last. When adv and no accept: p_valid <= 0. When !adv: stage 1 holds.
- Stage 2 (when adv && p_valid): sum = (first ? 0 : acc) + sign_ext(p) to ACC_W; two's-complement wrap, no overflow detection. cnt_sum = (first ? 1 : cnt+1).
  - Not last: acc <= sum, cnt <= cnt_sum, first <= 0.
  - Last: out_y <= sat(rnd(sum)), out_sat, out_taps <= cnt_sum, out_valid <= 1, first <= 1; acc unchanged (ignored next frame).
- out_valid clears when out_ready and no new last result lands the same edge; a new last result may be loaded on the same edge the old one is consumed (back-to-back results, no bubble).
- rnd(x), h = 2^(SHIFT-1), arithmetic shift:
  - mode 0: x >>> SHIFT.
  - mode 1/3: (x + h) >>> SHIFT.
  - mode 2: as mode 1, except when x[SHIFT-1:0] == h exactly, result is x >>> SHIFT rounded to the even neighbour.
  - Rounding addition computed at ACC_W+1 bits; no wrap.
- sat: clip to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out_sat = 1 when clipped. sat_sticky |= out_sat on each load.
- clr (priority over all except rstn): p_valid <= 0, out_valid <= 0, first <= 1, sat_sticky <= 0; in_ready low that cycle, so any in_valid is not accepted.

## Timing
- Reset values: in_ready 1 (after release), out_valid 0, out_y 0, out_sat 0, out_taps 0, sat_sticky 0; internal p_valid 0, first 1, acc 0, cnt 0.
- Throughput: one tap per cycle while out_ready held high.
- Latency: last tap accepted at edge E0 -> out_valid high after E0+1 (2-cycle latency, input to output register).
- Backpressure: out_valid && !out_ready freezes stage 1 and stage 2 and drops in_ready in the same cycle (combinational path out_ready -> in_ready). No tap is lost or duplicated.
- out_y, out_sat and out_taps are stable while out_valid && !out_ready.
- Single-tap frame (in_last on first tap): result = rnd/sat of that product alone, out_taps = 1.
- rstn assertion mid-frame or mid-stall: all state is immediately at reset values; the partial frame is discarded.

## Test plan
- Single tap 0x4000 x 0x4000, last, mode 0 -> out_y 0x0080, out_sat 0, out_taps 1, out_valid 2 cycles after accept; 0x8000 x 0x8000 -> 0x0200.
- Rounding: two taps of 0x0020 x 0x4000 (sum 2^20) -> mode 0 0x0000, mode 1 0x0001, mode 2 0x0000. Six such taps (3*2^20) -> modes 0/1/2 give 0x0001/0x0002/0x0002. One tap 0x0020 x 0x8000 (-2^20) -> modes 0/1/2 give 0xFFFF/0x0000/0x0000.
- Saturation: 100 taps 0x7FFF x 0x7FFF -> out_y 0x7FFF, out_sat 1, out_taps 100, sat_sticky 1. 100 taps 0x8000 x 0x7FFF -> 0x8000, out_sat 1. Then clr -> sat_sticky 0.
- Backpressure: stream 3 frames of 4 taps back-to-back with out_ready low for 5 cycles at first result -> in_ready low exactly while stalled; all 3 results correct, in order, no bubble after out_ready returns.
- clr mid-frame after 2 taps, then a 3-tap frame -> result reflects only the 3 new taps, out_taps 3; rstn pulsed mid-frame -> outputs return to reset values immediately.
- Random regression: random widths-compatible data, random valid/ready gaps, all round modes, compared with a golden model bit-exactly.

Source files
------------

// File: rtl/fir_mac_pipe_if.sv
// Tap-pair input stream and result output stream of the FIR multiply-accumulate engine.
// The engine side uses the slave modport; the tap sequencer / output FIFO side uses master.
interface fir_mac_pipe_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int OUT_W  = 16,
    parameter int CNT_W  = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_a;
    logic signed [COEF_W-1:0] in_b;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_y;
    logic                     out_sat;
    logic [CNT_W-1:0]         out_taps;

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_y, out_sat, out_taps
    );

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_y, out_sat, out_taps
    );
endinterface

// File: rtl/fir_mac_pipe.sv
// Two-stage pipelined MAC: stage 1 registers the product, stage 2 accumulates and, on the
// last tap of a frame, loads a rounded and saturated result into the output register.
module fir_mac_pipe #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int ACC_W  = 40,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 21,
    parameter int CNT_W  = 8
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           clr,
    input  logic [1:0]     round_mode,
    fir_mac_pipe_if.slave  bus,
    output logic           sat_sticky
);
    localparam int PW = DATA_W + COEF_W;
    localparam logic signed [ACC_W:0] HALF  = (ACC_W+1)'(1) <<< (SHIFT-1);
    localparam logic signed [ACC_W:0] Y_MAX = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] Y_MIN = {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

    logic                    adv;
    logic                    accept;
    logic                    load;
    logic signed [PW-1:0]    prod_next;

    logic signed [PW-1:0]    p_reg;
    logic                    p_valid_reg;
    logic                    p_last_reg;
    logic signed [ACC_W-1:0] acc_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic                    first_reg;
    logic signed [OUT_W-1:0] y_reg;
    logic                    sat_reg;
    logic [CNT_W-1:0]        taps_reg;
    logic                    out_valid_reg;
    logic                    sticky_reg;

    logic signed [ACC_W-1:0] sum_next;
    logic [CNT_W-1:0]        cnt_next;
    logic signed [ACC_W:0]   x_ext;
    logic signed [ACC_W:0]   q_floor;
    logic signed [ACC_W:0]   q_up;
    logic signed [ACC_W:0]   rnd_next;
    logic signed [OUT_W-1:0] y_next;
    logic                    sat_next;

    // The whole pipeline freezes while a result waits for the downstream FIFO.
    assign adv          = !out_valid_reg || bus.out_ready;
    assign bus.in_ready = adv && !clr;
    assign accept       = bus.in_valid && bus.in_ready;
    assign load         = adv && p_valid_reg && p_last_reg && !clr;
    assign prod_next    = bus.in_a * bus.in_b;

    assign bus.out_valid = out_valid_reg;
    assign bus.out_y     = y_reg;
    assign bus.out_sat   = sat_reg;
    assign bus.out_taps  = taps_reg;
    assign sat_sticky    = sticky_reg;

    always_comb begin
        sum_next = (first_reg ? '0 : acc_reg) + ACC_W'(p_reg);
        cnt_next = first_reg ? CNT_W'(1) : cnt_reg + 1'b1;
        x_ext    = {sum_next[ACC_W-1], sum_next};
        q_floor  = x_ext >>> SHIFT;
        q_up     = (x_ext + HALF) >>> SHIFT;
        rnd_next = q_up;
        case (round_mode)
            2'd0:    rnd_next = q_floor;
            // An exact half goes to whichever neighbour is even.
            2'd2:    rnd_next = (sum_next[SHIFT-1:0] == HALF[SHIFT-1:0])
                                ? q_floor + {{ACC_W{1'b0}}, q_floor[0]} : q_up;
            default: rnd_next = q_up;
        endcase
        sat_next = 1'b0;
        y_next   = rnd_next[OUT_W-1:0];
        if (rnd_next > Y_MAX) begin
            y_next   = Y_MAX[OUT_W-1:0];
            sat_next = 1'b1;
        end else if (rnd_next < Y_MIN) begin
            y_next   = Y_MIN[OUT_W-1:0];
            sat_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p_reg         <= '0;
            p_valid_reg   <= 1'b0;
            p_last_reg    <= 1'b0;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            first_reg     <= 1'b1;
            y_reg         <= '0;
            sat_reg       <= 1'b0;
            taps_reg      <= '0;
            out_valid_reg <= 1'b0;
            sticky_reg    <= 1'b0;
        end else if (clr) begin
            p_valid_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
            first_reg     <= 1'b1;
            sticky_reg    <= 1'b0;
        end else begin
            if (adv) begin
                p_valid_reg <= accept;
                if (accept) begin
                    p_reg      <= prod_next;
                    p_last_reg <= bus.in_last;
                end
            end
            if (adv && p_valid_reg) begin
                if (!p_last_reg) begin
                    acc_reg   <= sum_next;
                    cnt_reg   <= cnt_next;
                    first_reg <= 1'b0;
                end else begin
                    y_reg      <= y_next;
                    sat_reg    <= sat_next;
                    taps_reg   <= cnt_next;
                    first_reg  <= 1'b1;
                    sticky_reg <= sticky_reg | sat_next;
                end
            end
            if (load) begin
                out_valid_reg <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fir_mac_pipe.sv
// Scoreboard bench for fir_mac_pipe: directed frames with hand-derived results, then random
// frames checked against an integer model of accumulate / round / saturate.
module tb_fir_mac_pipe;
    localparam int DATA_W = 16, COEF_W = 16, ACC_W = 40, OUT_W = 16, SHIFT = 21, CNT_W = 8;

    typedef struct packed {
        logic [OUT_W-1:0] y;
        logic             sat;
        logic [CNT_W-1:0] taps;
    } res_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       clr = 1'b0;
    logic [1:0] round_mode = 2'd0;
    logic       sat_sticky;
    logic       rand_ready = 1'b0;
    logic       rdy_force = 1'b1;
    logic       rnd_bit = 1'b1;

    int      checks = 0;
    int      errors = 0;
    int      n_consumed = 0;
    res_t    exp_q[$];
    bit      use_model = 1'b0;
    longint  m_sum = 0;
    int      m_cnt = 0;

    fir_mac_pipe_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) bus ();

    fir_mac_pipe #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_W),
        .OUT_W(OUT_W), .SHIFT(SHIFT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rstn(rstn), .clr(clr), .round_mode(round_mode),
        .bus(bus), .sat_sticky(sat_sticky)
    );

    assign bus.out_ready = rand_ready ? rnd_bit : rdy_force;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1 rnd_bit = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic longint wrap_acc(input longint x);
        longint s;
        s = x <<< (64 - ACC_W);
        return s >>> (64 - ACC_W);
    endfunction

    // Floor quotient plus remainder, then apply the rounding rule and clip.
    function automatic res_t model_result(input longint s, input int n, input logic [1:0] m);
        longint q, r, half, hi, lo;
        res_t   o;
        half = 1;
        half = half <<< (SHIFT - 1);
        q = s >>> SHIFT;
        r = s - (q <<< SHIFT);
        if (m == 2'd2) begin
            if (r > half || (r == half && q[0])) q = q + 1;
        end else if (m != 2'd0) begin
            if (r >= half) q = q + 1;
        end
        hi = 1;
        hi = (hi <<< (OUT_W - 1)) - 1;
        lo = -hi - 1;
        o.sat = 1'b0;
        if (q > hi) begin q = hi; o.sat = 1'b1; end
        else if (q < lo) begin q = lo; o.sat = 1'b1; end
        o.y    = q[OUT_W-1:0];
        o.taps = n[CNT_W-1:0];
        return o;
    endfunction

    task automatic push_exp(input logic [OUT_W-1:0] y, input logic sat, input logic [CNT_W-1:0] taps);
        res_t e;
        e.y = y; e.sat = sat; e.taps = taps;
        exp_q.push_back(e);
    endtask

    task automatic send_tap(input logic [15:0] a, input logic [15:0] b, input logic last);
        int   cyc = 0;
        logic ok;
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_last = last;
        do begin
            @(negedge clk);
            ok = bus.in_ready;
            cyc++;
        end while (!ok && cyc < 500);
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout actual in_ready=0 for %0d cycles required=1", cyc);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        if (use_model) begin
            m_sum = wrap_acc(m_sum + longint'($signed(a)) * longint'($signed(b)));
            m_cnt++;
            if (last) begin
                exp_q.push_back(model_result(m_sum, m_cnt, round_mode));
                m_sum = 0; m_cnt = 0;
            end
        end
    endtask

    task automatic send_frame(input int n, input logic [15:0] a, input logic [15:0] b);
        for (int i = 0; i < n; i++) send_tap(a, b, i == n - 1);
    endtask

    task automatic drain(input string name);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 3000) begin
            @(posedge clk);
            cyc++;
        end
        @(posedge clk); #1;
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL %s_drain actual pending=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    always @(negedge clk) begin
        if (rstn && bus.out_valid && bus.out_ready) begin
            res_t got, want;
            got.y = bus.out_y; got.sat = bus.out_sat; got.taps = bus.out_taps;
            n_consumed++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL result%0d unexpected actual y=0x%04h sat=%0d taps=%0d required none",
                         n_consumed, got.y, got.sat, got.taps);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL result%0d actual y=0x%04h sat=%0d taps=%0d required y=0x%04h sat=%0d taps=%0d",
                             n_consumed, got.y, got.sat, got.taps, want.y, want.sat, want.taps);
                end else begin
                    $display("result%0d y=0x%04h sat=%0d taps=%0d mode=%0d", n_consumed,
                             got.y, got.sat, got.taps, round_mode);
                end
            end
        end
    end

    initial begin
        logic [15:0] exp2 [4];
        logic [15:0] exp6 [3];
        logic [15:0] expn [3];
        logic [15:0] y0;
        int          base, cyc;

        exp2[0] = 16'h0000; exp2[1] = 16'h0001; exp2[2] = 16'h0000; exp2[3] = 16'h0001;
        exp6[0] = 16'h0001; exp6[1] = 16'h0002; exp6[2] = 16'h0002;
        expn[0] = 16'hFFFF; expn[1] = 16'h0000; expn[2] = 16'h0000;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_last = 1'b0;

        repeat (3) @(posedge clk);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_out_y", bus.out_y, 0);
        chk("reset_out_sat", bus.out_sat, 0);
        chk("reset_out_taps", bus.out_taps, 0);
        chk("reset_sat_sticky", sat_sticky, 0);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;

        // Single-tap frames and 2-cycle latency.
        push_exp(16'h0080, 1'b0, 8'd1);
        send_tap(16'h4000, 16'h4000, 1'b1);
        @(negedge clk);
        chk("latency_edge1_out_valid", bus.out_valid, 0);
        @(negedge clk);
        chk("latency_edge2_out_valid", bus.out_valid, 1);
        drain("single");
        push_exp(16'h0200, 1'b0, 8'd1);
        send_tap(16'h8000, 16'h8000, 1'b1);
        drain("single_neg");

        // Rounding modes on exact-half and negative cases.
        for (int m = 0; m < 4; m++) begin
            round_mode = 2'(m);
            push_exp(exp2[m], 1'b0, 8'd2);
            send_frame(2, 16'h0020, 16'h4000);
            drain("round_half");
            if (m < 3) begin
                push_exp(exp6[m], 1'b0, 8'd6);
                send_frame(6, 16'h0020, 16'h4000);
                drain("round_three_half");
                push_exp(expn[m], 1'b0, 8'd1);
                send_frame(1, 16'h0020, 16'h8000);
                drain("round_neg_half");
            end
        end
        chk("sticky_clear_no_sat", sat_sticky, 0);

        // Saturation both ways, sticky flag, clr.
        round_mode = 2'd0;
        push_exp(16'h7FFF, 1'b1, 8'd100);
        send_frame(100, 16'h7FFF, 16'h7FFF);
        drain("sat_pos");
        chk("sticky_after_pos_sat", sat_sticky, 1);
        push_exp(16'h8000, 1'b1, 8'd100);
        send_frame(100, 16'h8000, 16'h7FFF);
        drain("sat_neg");
        chk("sticky_after_neg_sat", sat_sticky, 1);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk("sticky_after_clr", sat_sticky, 0);

        // Three 4-tap frames with a 5-cycle stall on the first result.
        push_exp(16'h0200, 1'b0, 8'd4);
        push_exp(16'h0100, 1'b0, 8'd4);
        push_exp(16'hFFA0, 1'b0, 8'd4);
        base = n_consumed;
        rdy_force = 1'b0;
        fork
            begin
                send_frame(4, 16'h4000, 16'h4000);
                send_frame(4, 16'h2000, 16'h4000);
                send_tap(16'h4000, 16'h4000, 1'b0);
                send_tap(16'h4000, 16'h8000, 1'b0);
                send_tap(16'h2000, 16'h2000, 1'b0);
                send_tap(16'h0100, 16'h0100, 1'b1);
            end
            begin
                cyc = 0;
                do begin
                    @(negedge clk);
                    cyc++;
                end while (!bus.out_valid && cyc < 100);
                chk("stall_first_result_seen", bus.out_valid, 1);
                y0 = bus.out_y;
                for (int i = 0; i < 5; i++) begin
                    chk("stall_in_ready", bus.in_ready, 0);
                    chk("stall_hold_y", bus.out_y, y0);
                    @(posedge clk); #1;
                end
                rdy_force = 1'b1;
                cyc = 0;
                while (n_consumed < base + 3 && cyc < 100) begin
                    @(posedge clk); #1;
                    cyc++;
                end
                chk("release_to_third_result_cycles", cyc, 9);
            end
        join
        drain("backpressure");

        // clr drops a partial frame and rejects the tap offered in the same cycle.
        send_tap(16'h7FFF, 16'h7FFF, 1'b0);
        send_tap(16'h7FFF, 16'h7FFF, 1'b0);
        clr = 1'b1;
        bus.in_valid = 1'b1; bus.in_a = 16'h7FFF; bus.in_b = 16'h7FFF; bus.in_last = 1'b1;
        @(negedge clk);
        chk("clr_in_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        clr = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
        push_exp(16'h0180, 1'b0, 8'd3);
        send_frame(3, 16'h4000, 16'h4000);
        drain("after_clr");

        // Asynchronous reset with a held result and a partial frame in flight.
        rdy_force = 1'b0;
        send_tap(16'h4000, 16'h4000, 1'b1);
        send_tap(16'h2000, 16'h2000, 1'b0);
        chk("pre_rst_out_valid", bus.out_valid, 1);
        chk("pre_rst_out_y", bus.out_y, 16'h0080);
        #3 rstn = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_y", bus.out_y, 0);
        chk("rst_out_taps", bus.out_taps, 0);
        chk("rst_out_sat", bus.out_sat, 0);
        chk("rst_sat_sticky", sat_sticky, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        rdy_force = 1'b1;
        @(negedge clk);
        chk("rst_release_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        push_exp(16'h0080, 1'b0, 8'd1);
        send_tap(16'h4000, 16'h4000, 1'b1);
        drain("after_rst");

        // Random frames against the model, one rounding mode per batch.
        use_model = 1'b1;
        for (int m = 0; m < 4; m++) begin
            round_mode = 2'(m);
            rand_ready = 1'b1;
            for (int f = 0; f < 25; f++) begin
                int          kind, len;
                logic [15:0] a, b;
                kind = $urandom_range(0, 5);
                len  = (kind == 0) ? $urandom_range(70, 120) : $urandom_range(1, 12);
                a = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h7FFF;
                for (int t = 0; t < len; t++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        repeat ($urandom_range(1, 3)) begin
                            @(posedge clk); #1;
                        end
                    end
                    if (kind == 0)
                        send_tap(a, 16'h7FFF, t == len - 1);
                    else if (kind == 1)
                        send_tap(16'($urandom_range(0, 63)), 16'h4000, t == len - 1);
                    else
                        send_tap(16'($urandom), 16'($urandom), t == len - 1);
                end
            end
            drain("random");
            rand_ready = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
